// File: rtl/crosshair_if.sv
// Pixel-stream bundle between the timing/background source, the crosshair
// overlay and the output stage.
interface crosshair_if;
  logic [9:0] px;
  logic [9:0] py;
  logic       video_active;
  logic       frame_start;
  logic       enable;
  logic       blink_en;
  logic       center;
  logic       move_left;
  logic       move_right;
  logic       move_up;
  logic       move_down;
  logic [7:0] bg_red;
  logic [7:0] bg_green;
  logic [7:0] bg_blue;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       video_active_out;
  logic [9:0] cross_x;
  logic [9:0] cross_y;

  modport master (
    output px, py, video_active, frame_start, enable, blink_en, center,
           move_left, move_right, move_up, move_down, bg_red, bg_green, bg_blue,
    input  red, green, blue, video_active_out, cross_x, cross_y
  );

  modport slave (
    input  px, py, video_active, frame_start, enable, blink_en, center,
           move_left, move_right, move_up, move_down, bg_red, bg_green, bg_blue,
    output red, green, blue, video_active_out, cross_x, cross_y
  );
endinterface

// File: rtl/crosshair_overlay.sv
// Movable, optionally blinking crosshair composited over a background pixel
// stream. The displayed position only changes on frame_start so a frame never
// tears; the composited pixel is registered (one cycle of latency).
module crosshair_overlay #(
  parameter int H_MAX        = 640,
  parameter int V_MAX        = 480,
  parameter int ARM          = 5,
  parameter int HALF_T       = 0,
  parameter int FULL_SPAN    = 0,
  parameter int STEP         = 4,
  parameter int BLINK_FRAMES = 30,
  parameter logic [23:0] CROSS_RGB = 24'hFFFFFF
) (
  input  logic       clk,
  input  logic       reset,
  crosshair_if.slave bus
);

  localparam logic [9:0]         CX0    = 10'(H_MAX / 2);
  localparam logic [9:0]         CY0    = 10'(V_MAX / 2);
  localparam logic signed [10:0] XMAX   = 11'(H_MAX - 1);
  localparam logic signed [10:0] YMAX   = 11'(V_MAX - 1);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam int                 CW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0]      LAST   = CW'(BLINK_FRAMES - 1);

  logic [9:0]         pend_x, pend_y;
  logic [9:0]         next_x, next_y;
  logic [9:0]         cx, cy;
  logic signed [10:0] sx, sy;
  logic [CW-1:0]      blink_cnt;
  logic               hidden;
  logic signed [10:0] dx, dy;
  logic [10:0]        adx, ady;
  logic               h_bar, v_bar, hit;

  // Next pending position: centre wins, opposing moves cancel, clamp to screen.
  always_comb begin
    sx = $signed({1'b0, pend_x});
    sy = $signed({1'b0, pend_y});
    if (bus.move_left && !bus.move_right) begin
      sx = sx - STEP_S;
    end else if (bus.move_right && !bus.move_left) begin
      sx = sx + STEP_S;
    end else begin
      sx = sx;
    end
    if (bus.move_up && !bus.move_down) begin
      sy = sy - STEP_S;
    end else if (bus.move_down && !bus.move_up) begin
      sy = sy + STEP_S;
    end else begin
      sy = sy;
    end
    if (sx < 11'sd0) begin
      next_x = 10'd0;
    end else if (sx > XMAX) begin
      next_x = XMAX[9:0];
    end else begin
      next_x = sx[9:0];
    end
    if (sy < 11'sd0) begin
      next_y = 10'd0;
    end else if (sy > YMAX) begin
      next_y = YMAX[9:0];
    end else begin
      next_y = sy[9:0];
    end
    if (bus.center) begin
      next_x = CX0;
      next_y = CY0;
    end else begin
      next_x = next_x;
      next_y = next_y;
    end
  end

  // Pending position tracks every clock; committed position latches the old
  // pending value on frame_start, so a same-cycle move lands next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_x <= CX0;
      pend_y <= CY0;
      cx     <= CX0;
      cy     <= CY0;
    end else begin
      pend_x <= next_x;
      pend_y <= next_y;
      if (bus.frame_start) begin
        cx <= pend_x;
        cy <= pend_y;
      end
    end
  end

  // Blink phase: count frames while enabled, toggle visibility on wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      hidden    <= 1'b0;
    end else if (!bus.blink_en) begin
      blink_cnt <= '0;
      hidden    <= 1'b0;
    end else if (bus.frame_start) begin
      if (blink_cnt == LAST) begin
        blink_cnt <= '0;
        hidden    <= ~hidden;
      end else begin
        blink_cnt <= blink_cnt + CW'(1);
      end
    end
  end

  // Hit test against the committed centre using signed distances.
  always_comb begin
    dx    = $signed({1'b0, bus.px}) - $signed({1'b0, cx});
    dy    = $signed({1'b0, bus.py}) - $signed({1'b0, cy});
    adx   = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    ady   = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    h_bar = (ady <= 11'(HALF_T)) && ((FULL_SPAN != 0) || (adx <= 11'(ARM)));
    v_bar = (adx <= 11'(HALF_T)) && ((FULL_SPAN != 0) || (ady <= 11'(ARM)));
    hit   = h_bar || v_bar;
  end

  // Registered composite: blank outside the active area, else crosshair or bg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.red              <= 8'd0;
      bus.green            <= 8'd0;
      bus.blue             <= 8'd0;
      bus.video_active_out <= 1'b0;
    end else begin
      bus.video_active_out <= bus.video_active;
      if (!bus.video_active) begin
        bus.red   <= 8'd0;
        bus.green <= 8'd0;
        bus.blue  <= 8'd0;
      end else if (hit && bus.enable && !hidden) begin
        bus.red   <= CROSS_RGB[23:16];
        bus.green <= CROSS_RGB[15:8];
        bus.blue  <= CROSS_RGB[7:0];
      end else begin
        bus.red   <= bus.bg_red;
        bus.green <= bus.bg_green;
        bus.blue  <= bus.bg_blue;
      end
    end
  end

  assign bus.cross_x = cx;
  assign bus.cross_y = cy;

endmodule

// File: tb/tb_crosshair_overlay.sv
// Scoreboard bench: dut_a uses default geometry with BLINK_FRAMES=2, dut_b uses
// FULL_SPAN=1/HALF_T=1. Both see identical inputs; each probe says which one
// is checked.
module tb_crosshair_overlay;

  typedef struct {
    int          dut;
    int          kind;   // 0 = pixel, 1 = committed position
    logic [23:0] rgb;
    logic        va;
    logic [9:0]  cx;
    logic [9:0]  cy;
    string       nm;
  } exp_t;

  localparam logic [23:0] BG = 24'h102030;
  localparam logic [23:0] XC = 24'hFFFFFF;

  logic clk = 1'b0;
  logic reset;
  logic [9:0] px, py;
  logic va, fs_s, en, blink, ctr, ml, mr, mu, md;
  int   probe_dut;
  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  crosshair_if ifa ();
  crosshair_if ifb ();

  assign ifa.px = px;          assign ifb.px = px;
  assign ifa.py = py;          assign ifb.py = py;
  assign ifa.video_active = va; assign ifb.video_active = va;
  assign ifa.frame_start = fs_s; assign ifb.frame_start = fs_s;
  assign ifa.enable = en;      assign ifb.enable = en;
  assign ifa.blink_en = blink; assign ifb.blink_en = blink;
  assign ifa.center = ctr;     assign ifb.center = ctr;
  assign ifa.move_left = ml;   assign ifb.move_left = ml;
  assign ifa.move_right = mr;  assign ifb.move_right = mr;
  assign ifa.move_up = mu;     assign ifb.move_up = mu;
  assign ifa.move_down = md;   assign ifb.move_down = md;
  assign ifa.bg_red = BG[23:16];  assign ifb.bg_red = BG[23:16];
  assign ifa.bg_green = BG[15:8]; assign ifb.bg_green = BG[15:8];
  assign ifa.bg_blue = BG[7:0];   assign ifb.bg_blue = BG[7:0];

  crosshair_overlay #(.BLINK_FRAMES(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  crosshair_overlay #(.FULL_SPAN(1), .HALF_T(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  // One cycle: clear pulses and probe; caller then sets this cycle's inputs.
  task automatic step();
    @(negedge clk);
    fs_s = 1'b0; ctr = 1'b0; ml = 1'b0; mr = 1'b0; mu = 1'b0; md = 1'b0;
    va = 1'b0; probe_dut = 0;
  endtask

  task automatic pix(input int d, input int x, input int y, input logic v,
                     input logic [23:0] rgb, input logic eva, input string nm);
    exp_t e;
    step();
    px = 10'(x); py = 10'(y); va = v; probe_dut = d;
    e.dut = d; e.kind = 0; e.rgb = rgb; e.va = eva; e.cx = 10'd0; e.cy = 10'd0; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic pos(input int d, input int x, input int y, input string nm);
    exp_t e;
    step();
    probe_dut = d;
    e.dut = d; e.kind = 1; e.rgb = 24'd0; e.va = 1'b0; e.cx = 10'(x); e.cy = 10'(y); e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic mv(input logic l, input logic r, input logic u, input logic dn,
                    input logic c, input logic f);
    step();
    ml = l; mr = r; mu = u; md = dn; ctr = c; fs_s = f;
  endtask

  task automatic frame();
    mv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: after each edge that captured a probe, pop and compare.
  initial begin
    int d;
    exp_t e;
    logic [23:0] g_rgb;
    logic g_va;
    logic [9:0] g_x, g_y;
    forever begin
      @(posedge clk);
      d = probe_dut;
      #1;
      if (d != 0) begin
        tot_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_underflow: got probe with no expected entry, required one");
        end else begin
          e = exp_q.pop_front();
          g_rgb = (e.dut == 1) ? {ifa.red, ifa.green, ifa.blue} : {ifb.red, ifb.green, ifb.blue};
          g_va  = (e.dut == 1) ? ifa.video_active_out : ifb.video_active_out;
          g_x   = (e.dut == 1) ? ifa.cross_x : ifb.cross_x;
          g_y   = (e.dut == 1) ? ifa.cross_y : ifb.cross_y;
          if (e.kind == 0) begin
            if (g_rgb === e.rgb && g_va === e.va) pass_cnt++;
            else $display("FAIL %s: got rgb=%06h va=%b, required rgb=%06h va=%b",
                          e.nm, g_rgb, g_va, e.rgb, e.va);
          end else begin
            if (g_x === e.cx && g_y === e.cy) pass_cnt++;
            else $display("FAIL %s: got cross=(%0d,%0d), required (%0d,%0d)",
                          e.nm, g_x, g_y, e.cx, e.cy);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b1; blink = 1'b0; px = 10'd0; py = 10'd0;
    va = 1'b0; fs_s = 1'b0; ctr = 1'b0; ml = 1'b0; mr = 1'b0; mu = 1'b0; md = 1'b0;
    probe_dut = 0;
    step();
    pix(1, 320, 240, 1'b1, 24'h000000, 1'b0, "reset_rgb");
    pos(1, 320, 240, "reset_pos");
    step(); reset = 1'b0;

    // Centre crosshair, ARM=5, HALF_T=0
    pix(1, 320, 240, 1'b1, XC, 1'b1, "centre_hit");
    pix(1, 325, 240, 1'b1, XC, 1'b1, "arm_end_x");
    pix(1, 326, 240, 1'b1, BG, 1'b1, "past_arm_x");
    pix(1, 320, 246, 1'b1, BG, 1'b1, "past_arm_y");
    pix(1, 320, 235, 1'b1, XC, 1'b1, "arm_end_up");
    pix(1, 320, 240, 1'b0, 24'h000000, 1'b0, "blanking");

    // Full-span, 3-pixel-thick variant
    pix(2, 0,   239, 1'b1, XC, 1'b1, "fs_row_left");
    pix(2, 639, 241, 1'b1, XC, 1'b1, "fs_row_right");
    pix(2, 319, 0,   1'b1, XC, 1'b1, "fs_col_top");
    pix(2, 321, 479, 1'b1, XC, 1'b1, "fs_col_bottom");
    pix(2, 100, 242, 1'b1, BG, 1'b1, "fs_below_row");
    pix(2, 322, 100, 1'b1, BG, 1'b1, "fs_beside_col");

    // Hidden when disabled
    step(); en = 1'b0;
    pix(1, 320, 240, 1'b1, BG, 1'b1, "disabled_a");
    pix(2, 0,   240, 1'b1, BG, 1'b1, "disabled_b");
    step(); en = 1'b1;

    // Moves only take effect at frame_start
    repeat (3) mv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pos(1, 320, 240, "pre_commit");
    frame();
    pos(1, 332, 240, "post_commit");
    pix(1, 337, 240, 1'b1, XC, 1'b1, "moved_arm_end");
    pix(1, 338, 240, 1'b1, BG, 1'b1, "moved_past_arm");
    pix(1, 332, 245, 1'b1, XC, 1'b1, "moved_vbar");

    // Right clamp (636 + 4 -> 639)
    repeat (77) mv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame();
    pos(1, 639, 240, "clamp_right");
    pix(1, 634, 240, 1'b1, XC, 1'b1, "right_arm_end");
    pix(1, 633, 240, 1'b1, BG, 1'b1, "right_past_arm");
    pix(1, 0,   240, 1'b1, BG, 1'b1, "right_no_wrap");

    // Left clamp to 0
    repeat (200) mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame();
    pos(1, 0, 240, "clamp_left");
    pix(1, 0,   240, 1'b1, XC, 1'b1, "edge_centre");
    pix(1, 5,   240, 1'b1, XC, 1'b1, "edge_arm_end");
    pix(1, 6,   240, 1'b1, BG, 1'b1, "edge_past_arm");
    pix(1, 639, 240, 1'b1, BG, 1'b1, "left_no_wrap");

    // Move coinciding with frame_start lands a frame later
    mv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    pos(1, 0, 240, "same_cycle_move");
    frame();
    pos(1, 0, 236, "next_frame_move");
    mv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frame();
    pos(1, 0, 236, "opposing_cancel");
    mv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    frame();
    pos(1, 320, 240, "center_priority");

    // Blink with BLINK_FRAMES=2
    step(); blink = 1'b1;
    pix(1, 320, 240, 1'b1, XC, 1'b1, "blink_f0");
    frame(); pix(1, 320, 240, 1'b1, XC, 1'b1, "blink_f1");
    frame(); pix(1, 320, 240, 1'b1, BG, 1'b1, "blink_f2");
    frame(); pix(1, 320, 240, 1'b1, BG, 1'b1, "blink_f3");
    frame(); pix(1, 320, 240, 1'b1, XC, 1'b1, "blink_f4");
    frame(); pix(1, 320, 240, 1'b1, XC, 1'b1, "blink_f5");
    frame(); pix(1, 320, 240, 1'b1, BG, 1'b1, "blink_f6");
    step(); blink = 1'b0;
    pix(1, 320, 240, 1'b1, XC, 1'b1, "blink_off");

    // Mid-frame reset
    mv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame();
    pos(1, 324, 240, "before_reset");
    step(); reset = 1'b1; px = 10'd324; py = 10'd240; va = 1'b1; probe_dut = 1;
    begin
      exp_t e;
      e.dut = 1; e.kind = 0; e.rgb = 24'h000000; e.va = 1'b0; e.cx = 10'd0; e.cy = 10'd0;
      e.nm = "midframe_reset";
      exp_q.push_back(e);
    end
    step(); reset = 1'b0;
    pos(1, 320, 240, "after_reset_pos");
    pix(1, 320, 240, 1'b1, XC, 1'b1, "after_reset_hit");

    repeat (3) step();
    tot_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/crosshair_overlay.md
Name: crosshair_overlay

Overview:
Parametrised, clocked successor to the fixed combinational crosshair renderer. Draws a movable, configurable-size, optionally blinking crosshair over an incoming background pixel stream. Sits between the pixel-timing generator/background source and the VGA/HDMI output stage. Position changes are frame-synchronised so a frame never tears, and the output is registered with one cycle of latency.

Parameters:
H_MAX, 640, active pixels per line; px range 0..H_MAX-1
V_MAX, 480, active lines per frame; py range 0..V_MAX-1
ARM, 5, arm half-length in pixels from centre (0 = centre only)
HALF_T, 0, bar half-thickness; bar is 2*HALF_T+1 pixels thick
FULL_SPAN, 0, 1 = bars span the whole screen (legacy look), 0 = bars limited to ARM
STEP, 4, pixels moved per move pulse
BLINK_FRAMES, 30, frames per blink phase (>=1)
CROSS_RGB, 24'hFFFFFF, crosshair colour {R,G,B}

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
px  in  10  current pixel x
py  in  10  current pixel y
video_active  in  1  px/py in visible area
frame_start  in  1  one-cycle pulse once per frame, during blanking
enable  in  1  0 = crosshair hidden, background passes through
blink_en  in  1  1 = blink crosshair
center  in  1  pulse: return pending position to screen centre
move_left, move_right, move_up, move_down  in  1 each  pulses: move pending position by STEP
bg_red, bg_green, bg_blue  in  8 each  background pixel
red, green, blue  out  8 each  composited pixel, registered
video_active_out  out  1  video_active delayed one cycle
cross_x, cross_y  out  10 each  committed (currently displayed) centre

Behaviour:
- Reset (async, active-high): pending and committed position = (H_MAX/2, V_MAX/2) = (320,240); blink counter 0, phase visible; red/green/blue = 0; video_active_out = 0.
- Pending position, updated every clock:
  - center has priority over all move inputs.
  - left+right in the same cycle: no x change. up+down in the same cycle: no y change. x and y move independently.
  - Arithmetic uses 11-bit signed values. Results clamp to [0, H_MAX-1] and [0, V_MAX-1], so there is no wrap. Example: x=2, left, STEP=4 gives x=0.
- Commit: on frame_start, committed position takes the pending value as registered before this cycle's update. A move arriving in the same cycle as frame_start appears in the next frame. cross_x/cross_y show the committed value.
- Blink:
  - blink_en=0: counter held at 0, phase visible.
  - blink_en=1: each frame_start increments the counter. When the counter reaches BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - Dropping blink_en forces visible on the next clock.
- Hit test, against the committed position (cx,cy), using 11-bit signed differences dx=px-cx and dy=py-cy:
  - h_bar = |dy|<=HALF_T and (FULL_SPAN or |dx|<=ARM)
  - v_bar = |dx|<=HALF_T and (FULL_SPAN or |dy|<=ARM)
  - hit = h_bar or v_bar. Parts of the crosshair off screen are simply clipped.
- Output register (1-cycle latency from px/py/bg/video_active):
  - if video_active=0: RGB = 0
  - else if hit and enable and phase visible: RGB = CROSS_RGB
  - else: RGB = bg
  - video_active_out = video_active delayed one cycle.
- The committed position changes only on frame_start, so the crosshair never moves mid-frame.
- Reset asserted mid-frame: outputs go to 0 immediately; operation resumes from centre after reset releases.

Test Plan:
- Reset, enable=1, sweep a frame with bg=0x102030 -> pixel (320,240) and (325,240) output FFFFFF one cycle later; (326,240) and (320,246) output 102030; video_active=0 gives 000000.
- Three move_right pulses then frame_start -> cross_x=332 only after frame_start; the hit then appears at (337,240) and not at (338,240).
- x=637: move_right -> clamps to 639. Then cx=0, ARM=5: pixel (0,240) is hit, and no wrap hit appears at (639,240).
- move_up together with frame_start -> cross_y unchanged that frame; it becomes 236 after the next frame_start. left+right in the same cycle -> x unchanged. center+move_down -> centre.
- blink_en=1, BLINK_FRAMES=2 -> visible for frames 0-1, hidden for 2-3, visible for 4-5. Clearing blink_en while hidden -> visible on the next clock.
- FULL_SPAN=1, HALF_T=1 -> rows 239..241 are fully coloured across x=0..639 and columns 319..321 across all y. enable=0 -> background passes through everywhere.
